csa_resolver: RTL and testbench

CSA_RESOLVER -- requirements
Module: csa_resolver

---
 rtl/csa_pkg.sv | 15 +
 rtl/csa_resolver_if.sv | 24 ++
 rtl/chunk_adder.sv | 24 ++
 rtl/csa_resolver.sv | 109 ++++++++++
 tb/tb_csa_resolver.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save resolver.
// Holds FSM encoding and the chunk-count math.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/csa_resolver_if.sv
// Operand/result handshake bundle for csa_resolver.
// master drives operands and consumes Result.
interface csa_resolver_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Sum;
  logic [WIDTH-1:0] Cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] Result;
  logic             busy;

  modport master (
    output in_valid, Sum, Cout, out_ready,
    input  in_ready, out_valid, Result, busy
  );

  modport slave (
    input  in_valid, Sum, Cout, out_ready,
    output in_ready, out_valid, Result, busy
  );
endinterface

// File: rtl/chunk_adder.sv
// N-bit combinational ripple adder with carry in/out.
// One chunk of the multi-cycle carry-save resolve.
module chunk_adder #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[N];
  end
endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save Sum/Cout pair to binary,
// CHUNK bits per cycle, LSB chunk first.
module csa_resolver
  import csa_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Sum,
  input  logic [WIDTH-1:0] Cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] Result,
  output logic             busy
);
  localparam int RW   = WIDTH + 2;
  localparam int CSAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCYC = ceil_div(RW, CSAFE);
  localparam int PW   = NCYC * CSAFE;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (CHUNK < 1 || CHUNK > WIDTH + 2) begin : g_bad_chunk
    $error("csa_resolver: CHUNK must be in 1..WIDTH+2");
  end

  state_e        state_q, state_d;
  logic [PW-1:0] s_q, s_d;
  logic [PW-1:0] c_q, c_d;
  logic [PW-1:0] res_q, res_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [CSAFE-1:0] sum_chunk;
  logic             cout_chunk;

  chunk_adder #(.N(CSAFE)) u_add (
    .a    (s_q[CSAFE-1:0]),
    .b    (c_q[CSAFE-1:0]),
    .cin  (carry_q),
    .s    (sum_chunk),
    .cout (cout_chunk)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = PW'({2'b00, Sum});
          c_d     = PW'({1'b0, Cout, 1'b0});
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // result fills from the top; padding bits fall off above RW
        s_d     = s_q >> CSAFE;
        c_d     = c_q >> CSAFE;
        res_d   = (res_q >> CSAFE)
                | (PW'(sum_chunk) << (PW - CSAFE));
        carry_d = cout_chunk;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NCYC - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign Result    = res_q[RW-1:0];
endmodule

// File: tb/tb_csa_resolver.sv
// Directed and randomized checks of csa_resolver
// at CHUNK = 2, 1 and 6 (WIDTH = 4).
module tb_csa_resolver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_resolver_if #(.WIDTH(4)) bus ();

  logic       ir1, ov1, bz1, ir6, ov6, bz6;
  logic [5:0] r1, r6;

  csa_resolver #(.WIDTH(4), .CHUNK(2)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(bus.in_valid), .in_ready(bus.in_ready),
    .Sum(bus.Sum), .Cout(bus.Cout),
    .out_valid(bus.out_valid), .out_ready(bus.out_ready),
    .Result(bus.Result), .busy(bus.busy)
  );

  csa_resolver #(.WIDTH(4), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst),
    .in_valid(bus.in_valid), .in_ready(ir1),
    .Sum(bus.Sum), .Cout(bus.Cout),
    .out_valid(ov1), .out_ready(bus.out_ready),
    .Result(r1), .busy(bz1)
  );

  csa_resolver #(.WIDTH(4), .CHUNK(6)) u_c6 (
    .clk(clk), .rst(rst),
    .in_valid(bus.in_valid), .in_ready(ir6),
    .Sum(bus.Sum), .Cout(bus.Cout),
    .out_valid(ov6), .out_ready(bus.out_ready),
    .Result(r6), .busy(bz6)
  );

  int         cur;
  int         n_cmp;
  int         n_bad;
  logic       s_ir, s_ov, s_bz;
  logic [5:0] s_res;

  always_comb begin
    s_ir  = bus.in_ready;
    s_ov  = bus.out_valid;
    s_bz  = bus.busy;
    s_res = bus.Result;
    case (cur)
      1: begin s_ir = ir1; s_ov = ov1; s_bz = bz1; s_res = r1; end
      2: begin s_ir = ir6; s_ov = ov6; s_bz = bz6; s_res = r6; end
      default: ;
    endcase
  end

  function automatic int ncyc(input int k);
    return (k == 1) ? 6 : (k == 2) ? 1 : 3;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s k=%0d: got %0h want %0h",
             tag, cur, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // mode: 0 out_ready low in RUN, 1 random, 2 held high
  task automatic xact(input int k, input logic [3:0] s,
                      input logic [3:0] c, input int stall,
                      input logic [5:0] exp, input int mode);
    int n;
    cur = k;
    n = 0;
    while (!s_ir && n < 50) begin
      bus.out_ready = 1'b1;
      tick();
      n++;
    end
    bus.out_ready = 1'b0;
    if (n >= 50) chk("idle_wait", 32'(n), 32'(0));
    bus.Sum      = s;
    bus.Cout     = c;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.Sum      = 4'($urandom);
    bus.Cout     = 4'($urandom);
    chk("busy_run", 32'(s_bz), 32'(1));
    chk("in_ready_run", 32'(s_ir), 32'(0));
    n = 1;
    while (!s_ov && n < 20) begin
      bus.out_ready = (mode == 2) ? 1'b1 :
                      (mode == 1) ? 1'($urandom) : 1'b0;
      tick();
      n++;
    end
    bus.out_ready = 1'b0;
    chk("latency", 32'(n), 32'(ncyc(k) + 1));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("hold_ov", 32'(s_ov), 32'(1));
      chk("hold_ir", 32'(s_ir), 32'(0));
      chk("hold_res", 32'(s_res), 32'(exp));
    end
    chk("result", 32'(s_res), 32'(exp));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("released_ir", 32'(s_ir), 32'(1));
    chk("released_ov", 32'(s_ov), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] a, b, ci, s, c;
    logic [5:0] e;
    n_cmp = 0;
    n_bad = 0;
    cur = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.Sum  = '0;
    bus.Cout = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(s_ir), 32'(1));
    chk("rst_out_valid", 32'(s_ov), 32'(0));
    chk("rst_busy", 32'(s_bz), 32'(0));
    chk("rst_result", 32'(s_res), 32'(0));

    xact(0, 4'b0000, 4'b1111, 0, 6'b011110, 0);
    xact(0, 4'b1111, 4'b1111, 1, 6'b101101, 0);
    xact(0, 4'b0011, 4'b0010, 0, 6'd7, 2);
    xact(0, 4'b0110, 4'b0001, 5, 6'b001000, 0);

    // reset wins over a simultaneous handshake
    bus.in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_prio_busy", 32'(s_bz), 32'(0));
    chk("rst_prio_ir", 32'(s_ir), 32'(1));
    tick();
    chk("rst_prio_idle", 32'(s_bz), 32'(0));

    // abort in the second RUN cycle
    bus.Sum = 4'b1010;
    bus.Cout = 4'b0101;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("abort_busy_pre", 32'(s_bz), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ir", 32'(s_ir), 32'(1));
    chk("abort_busy", 32'(s_bz), 32'(0));
    chk("abort_res", 32'(s_res), 32'(0));
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_ov", 32'(s_ov), 32'(0));
      tick();
    end
    xact(0, 4'b0001, 4'b0000, 0, 6'b000001, 0);

    for (int k = 0; k < 3; k++) begin
      pulse_rst();
      for (int v = 0; v < 200; v++) begin
        a  = 4'($urandom);
        b  = 4'($urandom);
        ci = 4'($urandom);
        s  = a ^ b ^ ci;
        c  = (a & b) | (a & ci) | (b & ci);
        e  = 6'(a) + 6'(b) + 6'(ci);
        xact(k, s, c, $urandom_range(0, 3), e, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
